// File: rtl/ihex_pkg.sv
// Shared types and constants for the Intel HEX ROM loader: parser states,
// record types and the ASCII characters the parser treats specially.
package ihex_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        ADDR,
        TYPE,
        DATA,
        EXT,
        SKIP,
        CSUM
    } state_t;

    localparam logic [7:0] REC_DATA = 8'h00;
    localparam logic [7:0] REC_EOF  = 8'h01;
    localparam logic [7:0] REC_ESA  = 8'h02;
    localparam logic [7:0] REC_SSA  = 8'h03;
    localparam logic [7:0] REC_ELA  = 8'h04;
    localparam logic [7:0] REC_SLA  = 8'h05;

    localparam logic [7:0] CHR_COLON = 8'h3A;
    localparam logic [7:0] CHR_CR    = 8'h0D;
    localparam logic [7:0] CHR_LF    = 8'h0A;
    localparam logic [7:0] CHR_SPACE = 8'h20;

endpackage

// File: rtl/ihex_rom_loader_hexdigit.sv
// Combinational ASCII classifier: hex digit to nibble, plus whitespace and
// record-start detection.
module ihex_hexdigit
    import ihex_pkg::*;
(
    input  logic [7:0] ch,
    output logic [3:0] nibble,
    output logic       is_hex,
    output logic       is_ws,
    output logic       is_colon
);

    always_comb begin
        nibble = 4'h0;
        is_hex = 1'b0;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            nibble = ch[3:0];
            is_hex = 1'b1;
        end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
            // 'A'/'a' have a low nibble of 1, so +9 lands on 10
            nibble = ch[3:0] + 4'd9;
            is_hex = 1'b1;
        end
    end

    assign is_ws    = (ch == CHR_CR) || (ch == CHR_LF) || (ch == CHR_SPACE);
    assign is_colon = (ch == CHR_COLON);

endmodule

// File: rtl/ihex_rom_loader.sv
// Download-stream to AVR program ROM loader: index 0 passes raw bytes through,
// any other index is parsed as Intel HEX with checksum and range checking.
module ihex_rom_loader
    import ihex_pkg::*;
#(
    parameter int ADDR_W        = 15,
    parameter int MAX_RECORDS_W = 12
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic                     ioctl_download,
    input  logic                     ioctl_wr,
    input  logic [7:0]               ioctl_index,
    input  logic [ADDR_W-1:0]        ioctl_addr,
    input  logic [7:0]               ioctl_dout,
    output logic                     rom_wr,
    output logic [ADDR_W-1:0]        rom_addr,
    output logic [7:0]               rom_data,
    output logic                     busy,
    output logic                     done,
    output logic                     err_csum,
    output logic                     err_syntax,
    output logic                     err_range,
    output logic [MAX_RECORDS_W-1:0] rec_count
);

    state_t state_reg, state_next;

    logic        download_prev_reg;
    logic        hex_mode_reg;
    logic        have_hi_reg;
    logic        idx_reg;
    logic        eof_seen_reg;
    logic [3:0]  hi_nib_reg;
    logic [7:0]  sum_reg;
    logic [7:0]  len_reg;
    logic [7:0]  type_reg;
    logic [7:0]  ext_hi_reg;
    logic [15:0] addr_reg;
    logic [31:0] ext_reg;

    logic [3:0]  nibble;
    logic        is_hex, is_ws, is_colon;
    logic [7:0]  cur_byte;
    logic [7:0]  csum_total;
    logic [31:0] eff_addr;
    logic        in_range;

    logic dl_rise, dl_fall;
    logic hex_wr, bin_wr;
    logic colon_in, bad_char, nib_store, byte_valid;

    logic              rom_wr_next;
    logic [ADDR_W-1:0] rom_addr_next;
    logic [7:0]        rom_data_next;
    logic              set_csum, set_syntax, set_range, rec_inc, eof_set;

    ihex_hexdigit u_hexdigit (
        .ch       (ioctl_dout),
        .nibble   (nibble),
        .is_hex   (is_hex),
        .is_ws    (is_ws),
        .is_colon (is_colon)
    );

    assign dl_rise = ioctl_download & ~download_prev_reg;
    assign dl_fall = ~ioctl_download & download_prev_reg;

    // The mode is latched on the rising edge, so a strobe in that same cycle is dropped
    assign hex_wr = ioctl_wr & ioctl_download & ~dl_rise & hex_mode_reg;
    assign bin_wr = ioctl_wr & ioctl_download & ~dl_rise & ~hex_mode_reg;

    assign colon_in   = hex_wr & is_colon;
    assign bad_char   = hex_wr & ~is_hex & ~is_colon & (~is_ws | have_hi_reg);
    assign nib_store  = hex_wr & is_hex & ~have_hi_reg & (state_reg != IDLE);
    assign byte_valid = hex_wr & is_hex & have_hi_reg & (state_reg != IDLE);

    assign cur_byte   = {hi_nib_reg, nibble};
    assign csum_total = sum_reg + cur_byte;
    assign eff_addr   = ext_reg + {16'h0000, addr_reg};
    assign in_range   = ~|eff_addr[31:ADDR_W];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (dl_rise || dl_fall) begin
            state_next = IDLE;
        end else if (colon_in) begin
            state_next = COUNT;
        end else if (bad_char) begin
            state_next = IDLE;
        end else if (byte_valid) begin
            case (state_reg)
                COUNT: state_next = ADDR;
                ADDR:  if (idx_reg) state_next = TYPE;
                TYPE: begin
                    case (cur_byte)
                        REC_DATA: begin
                            if (len_reg == 8'd0) state_next = CSUM;
                            else                 state_next = DATA;
                        end
                        REC_EOF:          state_next = CSUM;
                        REC_ESA, REC_ELA: state_next = EXT;
                        REC_SSA, REC_SLA: begin
                            if (len_reg == 8'd0) state_next = CSUM;
                            else                 state_next = SKIP;
                        end
                        default:          state_next = IDLE;
                    endcase
                end
                DATA, SKIP: if (len_reg == 8'd1) state_next = CSUM;
                EXT:        if (idx_reg) state_next = CSUM;
                CSUM:       state_next = IDLE;
                default:    state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        rom_wr_next   = 1'b0;
        rom_addr_next = '0;
        rom_data_next = 8'h00;
        set_csum      = 1'b0;
        set_syntax    = 1'b0;
        set_range     = 1'b0;
        rec_inc       = 1'b0;
        eof_set       = 1'b0;
        if (bin_wr) begin
            rom_wr_next   = 1'b1;
            rom_addr_next = ioctl_addr;
            rom_data_next = ioctl_dout;
        end
        if ((colon_in && state_reg != IDLE) || bad_char) begin
            set_syntax = 1'b1;
        end
        if (byte_valid) begin
            case (state_reg)
                TYPE: begin
                    if (!(cur_byte inside {REC_DATA, REC_EOF, REC_ESA, REC_SSA, REC_ELA, REC_SLA}))
                        set_syntax = 1'b1;
                end
                DATA: begin
                    if (in_range) begin
                        rom_wr_next   = 1'b1;
                        rom_addr_next = eff_addr[ADDR_W-1:0];
                        rom_data_next = cur_byte;
                    end else begin
                        set_range = 1'b1;
                    end
                end
                CSUM: begin
                    if (csum_total != 8'h00)       set_csum = 1'b1;
                    else if (type_reg == REC_DATA) rec_inc  = 1'b1;
                    if (type_reg == REC_EOF)       eof_set  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            download_prev_reg <= 1'b0;
            hex_mode_reg      <= 1'b0;
            have_hi_reg       <= 1'b0;
            idx_reg           <= 1'b0;
            eof_seen_reg      <= 1'b0;
            hi_nib_reg        <= 4'h0;
            sum_reg           <= 8'h00;
            len_reg           <= 8'h00;
            type_reg          <= 8'h00;
            ext_hi_reg        <= 8'h00;
            addr_reg          <= 16'h0000;
            ext_reg           <= 32'h0;
            rom_wr            <= 1'b0;
            rom_addr          <= '0;
            rom_data          <= 8'h00;
            busy              <= 1'b0;
            done              <= 1'b0;
            err_csum          <= 1'b0;
            err_syntax        <= 1'b0;
            err_range         <= 1'b0;
            rec_count         <= '0;
        end else begin
            download_prev_reg <= ioctl_download;
            rom_wr            <= rom_wr_next;
            rom_addr          <= rom_addr_next;
            rom_data          <= rom_data_next;
            if (dl_rise) begin
                hex_mode_reg <= (ioctl_index != 8'd0);
                busy         <= 1'b1;
                done         <= 1'b0;
                err_csum     <= 1'b0;
                err_syntax   <= 1'b0;
                err_range    <= 1'b0;
                rec_count    <= '0;
                eof_seen_reg <= 1'b0;
                have_hi_reg  <= 1'b0;
                ext_reg      <= 32'h0;
            end else if (dl_fall) begin
                busy        <= 1'b0;
                have_hi_reg <= 1'b0;
                done        <= ~(err_csum | err_syntax | err_range) & (~hex_mode_reg | eof_seen_reg);
            end else begin
                if (set_csum)   err_csum   <= 1'b1;
                if (set_syntax) err_syntax <= 1'b1;
                if (set_range)  err_range  <= 1'b1;
                if (eof_set)    eof_seen_reg <= 1'b1;
                if (rec_inc && rec_count != '1) rec_count <= rec_count + 1'b1;

                if (colon_in) begin
                    sum_reg     <= 8'h00;
                    have_hi_reg <= 1'b0;
                    idx_reg     <= 1'b0;
                end else if (bad_char) begin
                    have_hi_reg <= 1'b0;
                end else if (nib_store) begin
                    hi_nib_reg  <= nibble;
                    have_hi_reg <= 1'b1;
                end else if (byte_valid) begin
                    have_hi_reg <= 1'b0;
                    sum_reg     <= csum_total;
                    case (state_reg)
                        COUNT: begin
                            len_reg <= cur_byte;
                            idx_reg <= 1'b0;
                        end
                        ADDR: begin
                            if (!idx_reg) addr_reg[15:8] <= cur_byte;
                            else          addr_reg[7:0]  <= cur_byte;
                            idx_reg <= ~idx_reg;
                        end
                        TYPE: begin
                            type_reg <= cur_byte;
                            idx_reg  <= 1'b0;
                        end
                        DATA: begin
                            addr_reg <= addr_reg + 16'd1;
                            len_reg  <= len_reg - 8'd1;
                        end
                        SKIP: len_reg <= len_reg - 8'd1;
                        EXT: begin
                            if (!idx_reg) begin
                                ext_hi_reg <= cur_byte;
                                idx_reg    <= 1'b1;
                            end else if (type_reg == REC_ELA) begin
                                ext_reg <= {ext_hi_reg, cur_byte, 16'h0000};
                            end else begin
                                ext_reg <= {12'h000, ext_hi_reg, cur_byte, 4'h0};
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_ihex_rom_loader.sv
// Directed bench for ihex_rom_loader: binary pass-through, HEX parsing,
// checksum, range, syntax, dropped download and asynchronous reset.
module tb_ihex_rom_loader;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [7:0]  ioctl_index;
    logic [14:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        rom_wr;
    logic [14:0] rom_addr;
    logic [7:0]  rom_data;
    logic        busy, done, err_csum, err_syntax, err_range;
    logic [11:0] rec_count;

    int tests = 0;
    int fails = 0;
    logic [22:0] wr_log[$];

    always #5 clk_sys = ~clk_sys;

    ihex_rom_loader #(.ADDR_W(15), .MAX_RECORDS_W(12)) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_index    (ioctl_index),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .rom_wr         (rom_wr),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .busy           (busy),
        .done           (done),
        .err_csum       (err_csum),
        .err_syntax     (err_syntax),
        .err_range      (err_range),
        .rec_count      (rec_count)
    );

    always @(negedge clk_sys) begin
        if (rom_wr === 1'b1) wr_log.push_back({rom_addr, rom_data});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("[TB] check %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send_char(input logic [7:0] c);
        @(negedge clk_sys);
        ioctl_dout = c;
        ioctl_wr   = 1'b1;
        @(negedge clk_sys);
        ioctl_wr   = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic crlf();
        send_char(8'h0D);
        send_char(8'h0A);
    endtask

    task automatic dl_start(input logic [7:0] idx);
        @(negedge clk_sys);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        wr_log.delete();
    endtask

    task automatic dl_end();
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        @(negedge clk_sys);
    endtask

    logic [7:0] bin_data [4];

    initial begin
        bin_data[0] = 8'h0C; bin_data[1] = 8'h94; bin_data[2] = 8'h5C; bin_data[3] = 8'h00;
        reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
        ioctl_index = 8'h00; ioctl_addr = '0; ioctl_dout = 8'h00;
        repeat (3) @(negedge clk_sys);
        check("reset_outputs", {rom_wr, busy, done, err_csum, err_syntax, err_range}, 32'h0);
        check("reset_rec_count", {20'h0, rec_count}, 32'h0);
        reset_n = 1'b1;

        // Binary pass-through with one-cycle latency
        dl_start(8'h00);
        check("bin_busy", {31'h0, busy}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            ioctl_addr = 15'(i);
            send_char(bin_data[i]);
            check("bin_wr", {8'h0, rom_wr, rom_addr, rom_data}, {8'h0, 1'b1, 15'(i), bin_data[i]});
        end
        dl_end();
        check("bin_done_busy", {30'h0, done, busy}, 32'h2);
        check("bin_wr_count", wr_log.size(), 32'd4);

        // Good HEX data record plus EOF
        dl_start(8'h01);
        send_str(":020010000C");
        send_char("9");
        check("hex_no_wr_hi_nibble", {31'h0, rom_wr}, 32'h0);
        send_char("4");
        check("hex_wr_latency", {8'h0, rom_wr, rom_addr, rom_data}, {8'h0, 1'b1, 15'h0011, 8'h94});
        send_str("4E"); crlf();
        send_str(":00000001FF"); crlf();
        dl_end();
        check("hex_wr_count", wr_log.size(), 32'd2);
        check("hex_wr0", {9'h0, wr_log[0]}, {9'h0, 15'h0010, 8'h0C});
        check("hex_wr1", {9'h0, wr_log[1]}, {9'h0, 15'h0011, 8'h94});
        check("hex_rec_count", {20'h0, rec_count}, 32'd1);
        check("hex_done_errs", {28'h0, done, err_csum, err_syntax, err_range}, 32'h8);

        // Bad checksum: writes still happen, no done
        dl_start(8'h01);
        send_str(":020010000C944F"); crlf();
        send_str(":00000001FF"); crlf();
        dl_end();
        check("csum_wr_count", wr_log.size(), 32'd2);
        check("csum_flags", {28'h0, done, err_csum, err_syntax, err_range}, 32'h4);
        check("csum_rec_count", {20'h0, rec_count}, 32'd0);

        // Extended linear address pushes data above the ROM
        dl_start(8'h01);
        send_str(":020000040001F9"); crlf();
        send_str(":01000000AA55"); crlf();
        send_str(":00000001FF"); crlf();
        dl_end();
        check("range_wr_count", wr_log.size(), 32'd0);
        check("range_flags", {28'h0, done, err_csum, err_syntax, err_range}, 32'h1);
        check("range_rec_count", {20'h0, rec_count}, 32'd1);

        // Lowercase digits, stray 'G', then parsing resumes at the next ':'
        dl_start(8'h05);
        send_str(":020010000c944e"); crlf();
        send_str(":0200G");
        send_str(":01002000AB34"); crlf();
        send_str(":00000001FF"); crlf();
        dl_end();
        check("syn_wr_count", wr_log.size(), 32'd3);
        check("syn_wr0", {9'h0, wr_log[0]}, {9'h0, 15'h0010, 8'h0C});
        check("syn_wr2", {9'h0, wr_log[2]}, {9'h0, 15'h0020, 8'hAB});
        check("syn_flags", {28'h0, done, err_csum, err_syntax, err_range}, 32'h2);
        check("syn_rec_count", {20'h0, rec_count}, 32'd2);

        // Download dropped mid-record, then a clean EOF-only load
        dl_start(8'h01);
        send_str(":0000");
        dl_end();
        check("drop_done_busy", {30'h0, done, busy}, 32'h0);
        dl_start(8'h01);
        send_str(":00000001FF"); crlf();
        dl_end();
        check("drop_recover_done", {31'h0, done}, 32'h1);

        // Asynchronous reset in the middle of a data record
        dl_start(8'h01);
        send_str(":04003000112");
        check("pre_reset_busy", {31'h0, busy}, 32'h1);
        #2;
        reset_n = 1'b0;
        ioctl_download = 1'b0;
        #1;
        check("async_reset_outputs", {26'h0, rom_wr, busy, done, err_csum, err_syntax, err_range}, 32'h0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        dl_start(8'h01);
        send_str(":00000001FF"); crlf();
        dl_end();
        check("post_reset_done", {28'h0, done, err_csum, err_syntax, err_range}, 32'h8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ihex_rom_loader.md
Name: ihex_rom_loader

Overview:
- Sits between the HPS ioctl download stream and the 32 KB AVR program ROM (16384 x 16-bit, byte-addressed on the write side).
- Index 0 files are raw binary and pass straight through as byte writes.
- Any other index is parsed as Intel HEX text: ASCII decode, record framing, checksum verification, and byte writes to the ROM.
- Replaces the ad-hoc inline parser and adds error reporting and a load-complete indication for the reset logic.

Parameters:
- ADDR_W, 15, ROM byte-address width (32 KB)
- MAX_RECORDS_W, 12, width of the good-record counter

Ports:
- clk_sys  in  1  system clock; all logic on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- ioctl_download  in  1  download window active
- ioctl_wr  in  1  one-cycle strobe; ioctl_dout is valid
- ioctl_index  in  8  file index; 0 = binary, nonzero = HEX
- ioctl_addr  in  ADDR_W  byte offset in the file (binary mode only)
- ioctl_dout  in  8  file byte
- rom_wr  out  1  one-cycle ROM byte write strobe
- rom_addr  out  ADDR_W  ROM byte address (bit 0 selects the byte lane)
- rom_data  out  8  ROM byte
- busy  out  1  high while a download is in progress
- done  out  1  sticky; load finished cleanly
- err_csum  out  1  sticky; at least one record failed its checksum
- err_syntax  out  1  sticky; illegal character or unsupported record type
- err_range  out  1  sticky; a data byte fell outside ROM, write suppressed
- rec_count  out  MAX_RECORDS_W  count of good data records (saturating)

Behaviour:
- Reset (reset_n low, asynchronous): all outputs 0; FSM in IDLE.
- Rising edge of ioctl_download: clear done, all err_*, and rec_count; set busy; FSM to IDLE.
- Falling edge of ioctl_download: busy to 0. done to 1 if no err_* is set and, in HEX mode, an EOF record was seen. Binary mode needs no EOF.
- Download dropped mid-record: FSM to IDLE, busy to 0, done stays 0.
- Binary mode (ioctl_index == 0): on ioctl_wr, the next cycle has rom_wr=1, rom_addr=ioctl_addr, rom_data=ioctl_dout. Latency is 1 cycle.
- HEX mode, character classes:
  - 0-9, A-F, a-f convert to a nibble.
  - CR, LF and space are ignored everywhere outside the middle of a byte.
  - ':' is the record start.
  - Any other character sets err_syntax and sends the FSM to IDLE.
- Byte assembly: a hi/lo nibble flag; a full byte forms on the second nibble. Every full byte is added mod 256 into sum.
- FSM (advances only on ioctl_wr):
  - IDLE: wait for ':'. Then clear sum, go to COUNT.
  - COUNT: 1 byte into len.
  - ADDR: 2 bytes into a 16-bit addr, high byte first.
  - TYPE: 1 byte.
    - 00 goes to DATA, or to CSUM if len == 0.
    - 01 goes to CSUM (EOF).
    - 02 and 04 go to EXT.
    - 03 and 05 go to SKIP.
    - Any other type sets err_syntax and goes to IDLE.
  - DATA:
    - Each byte produces rom_wr, with rom_addr = {ext, addr} truncated to ADDR_W and rom_data = the byte.
    - addr increments and wraps at 16 bits; len decrements.
    - len reaching 0 goes to CSUM.
  - EXT: 2 bytes.
    - Type 04: ext = value << 16.
    - Type 02: ext = value << 4.
    - Then go to CSUM.
  - SKIP: consume len bytes into sum, then go to CSUM.
  - CSUM: 1 byte.
    - If the final sum != 0, set err_csum.
    - If the sum is good and the type is 00, increment rec_count (saturating).
    - If the type is 01, latch eof_seen and go to IDLE; further records are still parsed.
- Range: any data byte whose effective address is >= 2^ADDR_W gets no rom_wr and sets err_range.
- Data is written before its checksum is known. A bad checksum does not roll back the writes.
- rom_wr timing (HEX mode): asserted exactly one cycle after the ioctl_wr carrying the low nibble. Never asserted two cycles in a row.
- ':' seen in any non-IDLE state: treated as a new record start, and err_syntax is set.

Decomposition:
- Package ihex_pkg holds:
  - state enum (IDLE, COUNT, ADDR, TYPE, DATA, EXT, SKIP, CSUM)
  - record-type constants (REC_DATA=8'h00, REC_EOF=8'h01, REC_ESA=8'h02, REC_ELA=8'h04)
  - ASCII constants (':', CR, LF)
- One natural sub-module, ihex_hexdigit: combinational ASCII-to-nibble conversion plus a valid/whitespace/colon classifier.

Test Plan:
- Binary mode, index 0: 4 bytes at ioctl_addr 0..3 with data 0C,94,5C,00 -> four rom_wr pulses at addresses 0..3 with the same data, each 1 cycle later; done=1 at the end.
- HEX ":020010000C94" + sum byte "4E" + CRLF + ":00000001FF" -> rom_wr at addr 0x0010 = 0C, at 0x0011 = 94; rec_count=1; done=1; no errors.
- Same data record with a wrong checksum byte "4F" -> both bytes still written; err_csum=1; rec_count=0; done=0.
- ":020000040001F9" then a data record at addr 0x0000 -> effective address 0x10000, no rom_wr, err_range=1.
- Lowercase "0c" and a stray 'G' mid-record -> lowercase accepted; 'G' sets err_syntax, FSM to IDLE, next ':' resumes parsing.
- reset_n pulsed low mid-DATA -> outputs 0 immediately (asynchronous); a following ":00000001FF" with the download window toggled -> done=1.
